// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receive path
// Purpose: frame FSM state encoding, prefix byte values, frame length and the
//          per-player scan codes consumed by the downstream key decoder.
// Ports:   none (package)
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // Player 1 on W/A/S/D, player 2 on the arrow cluster (E0-prefixed).
    localparam logic [7:0] KEY_P1_UP    = 8'h1D;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h23;
    localparam logic [7:0] KEY_P2_UP    = 8'h75;
    localparam logic [7:0] KEY_P2_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_P2_DOWN  = 8'h72;
    localparam logic [7:0] KEY_P2_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// rtl/ps2_frame_receiver_if.sv - pin and event bundle of the PS/2 frame receiver
// Purpose: groups the raw PS/2 pins and the byte/key event outputs.
// Ports:   ps2_clk, ps2_dat          raw pins toward the receiver
//          byte_valid, byte_data     validated byte event
//          frame_err                 bad frame / timeout pulse
//          key_valid, key_code,
//          key_ext, key_break        folded key event
// Modports: slave  = receiver side, master = pin driver / event consumer
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;

    modport slave (
        input  ps2_clk, ps2_dat,
        output byte_valid, byte_data, frame_err,
        output key_valid, key_code, key_ext, key_break
    );

    modport master (
        output ps2_clk, ps2_dat,
        input  byte_valid, byte_data, frame_err,
        input  key_valid, key_code, key_ext, key_break
    );
endinterface

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - pin synchroniser and PS2_CLK falling-edge strobe
// Purpose: two-flop synchronises both pins, detects PS2_CLK falling edges and
//          presents the data sample aligned with a one-cycle fall strobe.
// Ports:   clk, reset (sync, active-high)
//          i_ps2_clk, i_ps2_dat  raw asynchronous pins
//          o_dat                 synchronised data sampled with the edge
//          o_fall                one-cycle strobe per PS2_CLK falling edge
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_dat,
    output logic o_fall
);
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic r_dat, r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle bus is high; resetting to 1 keeps a spurious fall away.
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_dat      <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_dat;
            r_dat_s2   <= r_dat_s1;
            // Strobe and its data sample are registered together so they
            // stay aligned for the frame FSM.
            r_fall     <= r_clk_prev & ~r_clk_s2;
            r_dat      <= r_dat_s2;
        end
    end

    assign o_dat  = r_dat;
    assign o_fall = r_fall;
endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 device-to-host frame receiver with prefix folding
// Purpose: deserialises 11-bit PS/2 frames in the clk domain, emits validated
//          bytes and folds E0/F0 prefixes into one key event per keystroke.
//          Optional macro PS2_TIMEOUT_EN adds a mid-frame inactivity abort.
// Ports:   clk, reset (sync, active-high)
//          bus (ps2_frame_receiver_if.slave): pins in, byte/key events out
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    ps2_frame_receiver_if.slave         bus
);
    logic       w_dat, w_fall;
    ps2_state_t r_state, w_next;
    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;
    logic       r_parity;
    logic       r_ext, r_brk;
    logic       r_byte_valid, r_frame_err, r_key_valid;
    logic [7:0] r_byte_data, r_key_code;
    logic       r_key_ext, r_key_break;
    logic       w_timeout, w_stop_fall, w_frame_ok, w_accept, w_err, w_key;
    logic       w_is_ext, w_is_brk;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .i_ps2_clk(bus.ps2_clk),
        .i_ps2_dat(bus.ps2_dat),
        .o_dat    (w_dat),
        .o_fall   (w_fall)
    );

`ifdef PS2_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state == IDLE || w_fall || w_timeout)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // A real edge in the same cycle wins over the abort.
    assign w_timeout = (r_state != IDLE) && !w_fall &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT_CYCLES[0], CNT_W[0]};
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (!w_dat) w_next = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_next = PARITY;
                PARITY:  w_next = STOP;
                STOP:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_stop_fall = w_fall && (r_state == STOP);
        // Odd parity: data bits plus parity bit must hold an odd count of ones.
        w_frame_ok  = w_dat && (^{r_shreg, r_parity});
        w_accept    = w_stop_fall && w_frame_ok;
        w_err       = (w_stop_fall && !w_frame_ok) || w_timeout;
        w_is_ext    = (r_shreg == PS2_EXT_PREFIX);
        w_is_brk    = (r_shreg == PS2_BRK_PREFIX);
        w_key       = w_accept && !w_is_ext && !w_is_brk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_parity     <= 1'b0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
            r_key_valid  <= 1'b0;
            r_key_code   <= '0;
            r_key_ext    <= 1'b0;
            r_key_break  <= 1'b0;
        end else begin
            r_byte_valid <= w_accept;
            r_frame_err  <= w_err;
            r_key_valid  <= w_key;

            if (w_fall && !w_timeout) begin
                case (r_state)
                    IDLE:    r_bit_cnt <= '0;
                    DATA: begin
                        r_shreg   <= {w_dat, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY:  r_parity <= w_dat;
                    default: ;
                endcase
            end

            if (w_accept) r_byte_data <= r_shreg;

            if (w_key) begin
                r_key_code  <= r_shreg;
                r_key_ext   <= r_ext;
                r_key_break <= r_brk;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else if (w_accept && w_is_ext) begin
                r_ext <= 1'b1;
            end else if (w_accept && w_is_brk) begin
                r_brk <= 1'b1;
            end else if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_data  = r_byte_data;
    assign bus.frame_err  = r_frame_err;
    assign bus.key_valid  = r_key_valid;
    assign bus.key_code   = r_key_code;
    assign bus.key_ext    = r_key_ext;
    assign bus.key_break  = r_key_break;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb/tb_ps2_frame_receiver.sv - scoreboard bench for ps2_frame_receiver
module tb_ps2_frame_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;

    ps2_frame_receiver_if bus();

    ps2_frame_receiver #(
        .TIMEOUT_CYCLES(2000),
        .CNT_W         (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } byte_exp_t;

    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         brk;
    } key_exp_t;

    byte_exp_t exp_b[$];
    key_exp_t  exp_k[$];
    byte_exp_t mb;
    key_exp_t  mk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int last_byte_cyc = 0;
    int pulse_cnt = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clk) begin
        if (bus.byte_valid || bus.frame_err) begin
            checks++;
            pulse_cnt++;
            last_byte_cyc = cyc;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected: got byte_valid=%0b frame_err=%0b byte_data=%02h, required no pulse",
                         bus.byte_valid, bus.frame_err, bus.byte_data);
            end else begin
                mb = exp_b.pop_front();
                if (bus.frame_err !== mb.err || bus.byte_valid !== !mb.err ||
                    (!mb.err && bus.byte_data !== mb.data)) begin
                    errors++;
                    $display("FAIL byte_event: got byte_valid=%0b frame_err=%0b byte_data=%02h, required frame_err=%0b byte_data=%02h",
                             bus.byte_valid, bus.frame_err, bus.byte_data, mb.err, mb.data);
                end
            end
        end
        if (bus.key_valid) begin
            checks++;
            pulse_cnt++;
            if (exp_k.size() == 0) begin
                errors++;
                $display("FAIL key_unexpected: got key_code=%02h ext=%0b brk=%0b, required no pulse",
                         bus.key_code, bus.key_ext, bus.key_break);
            end else begin
                mk = exp_k.pop_front();
                if (bus.key_code !== mk.code || bus.key_ext !== mk.ext || bus.key_break !== mk.brk) begin
                    errors++;
                    $display("FAIL key_event: got key_code=%02h ext=%0b brk=%0b, required key_code=%02h ext=%0b brk=%0b",
                             bus.key_code, bus.key_ext, bus.key_break, mk.code, mk.ext, mk.brk);
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        byte_exp_t e;
        e.err = 1'b0; e.data = d;
        exp_b.push_back(e);
    endtask

    task automatic push_err();
        byte_exp_t e;
        e.err = 1'b1; e.data = 8'h00;
        exp_b.push_back(e);
    endtask

    task automatic push_key(input logic [7:0] c, input bit x, input bit b);
        key_exp_t e;
        e.code = c; e.ext = x; e.brk = b;
        exp_k.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic ps2_bit(input bit b);
        @(negedge clk);
        bus.ps2_dat = b;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        stop_cyc = cyc;
        repeat (8) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stp);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_b.size() != 0 || exp_k.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_b.size() != 0 || exp_k.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got pending byte=%0d key=%0d, required 0 0",
                     name, exp_b.size(), exp_k.size());
            exp_b.delete();
            exp_k.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("rst_byte_data",  {24'd0, bus.byte_data},  32'd0);
        chk("rst_frame_err",  {31'd0, bus.frame_err},  32'd0);
        chk("rst_key_valid",  {31'd0, bus.key_valid},  32'd0);
        chk("rst_key_code",   {24'd0, bus.key_code},   32'd0);
        chk("rst_key_ext",    {31'd0, bus.key_ext},    32'd0);
        chk("rst_key_break",  {31'd0, bus.key_break},  32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Plain make code 1C, parity 0.
        push_byte(8'h1C); push_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("plain_1c");
        chk("latency_1c", last_byte_cyc - stop_cyc, 32'd4);
        chk("held_byte_1c", {24'd0, bus.byte_data}, 32'h1C);
        chk("held_key_1c",  {24'd0, bus.key_code},  32'h1C);

        // Break: F0 (parity 1) then 1C.
        push_byte(8'hF0); push_byte(8'h1C); push_key(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("break_1c");

        // Extended break E0 F0 75, then plain 75.
        push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75); push_key(8'h75, 1'b1, 1'b1);
        push_byte(8'h75); push_key(8'h75, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("ext_break_75");

        // Bad parity, then bad stop bit.
        push_err();
        send_frame(8'h1C, 1'b1, 1'b1);
        push_err();
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("bad_frames");
        chk("held_byte_after_err", {24'd0, bus.byte_data}, 32'h75);

        // F0 followed by a bad frame drops the break flag.
        push_byte(8'hF0); push_err(); push_byte(8'h1C); push_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("brk_cleared");

        // Reset after start + 4 data bits discards the partial frame.
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        pc = pulse_cnt;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_no_pulse", pulse_cnt, pc);
        push_byte(8'h75); push_key(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("after_reset");
        chk("byte_after_reset", {24'd0, bus.byte_data}, 32'h75);

        // Stall after start + 3 data bits (4 edges into the frame).
        ps2_bit(1'b0);
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
        pc = pulse_cnt;
`ifdef PS2_TIMEOUT_EN
        push_err();
        begin
            int n;
            n = 0;
            while (exp_b.size() != 0 && n < 2500) begin
                @(negedge clk);
                n++;
            end
        end
        drain("timeout");
        checks++;
        if (last_byte_cyc - stop_cyc < 2000 || last_byte_cyc - stop_cyc > 2010) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d, required 2000..2010", last_byte_cyc - stop_cyc);
        end
`else
        repeat (2500) @(negedge clk);
        chk("stall_no_err", pulse_cnt, pc);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
`endif
        push_byte(8'h1C); push_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("after_stall");

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Upstream front end for the PS/2 key decoder. Samples the raw PS2_CLK/PS2_DAT pins in the clk domain and deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop). Emits validated bytes, then folds E0 (extended) and F0 (break) prefixes into one key event per keystroke. Replaces the free-running negedge-PS2_CLK shift register; downstream decode runs fully synchronous to clk.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles of bus inactivity mid-frame before abort (1 ms at 50 MHz); used only with PS2_TIMEOUT_EN
CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS2_CLK pin, asynchronous
ps2_dat  in  1  raw PS2_DAT pin, asynchronous
byte_valid  out  1  one-cycle pulse: byte_data holds a new validated byte
byte_data  out  8  last validated byte; held between pulses
frame_err  out  1  one-cycle pulse: parity error, stop bit 0, or timeout
key_valid  out  1  one-cycle pulse: key event on key_code/key_ext/key_break
key_code  out  8  scan code of the last key event; held
key_ext  out  1  last key event was E0-prefixed; held
key_break  out  1  last key event was a release (F0-prefixed); held

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high. Reset values: all outputs 0. FSM is IDLE. Prefix flags are 0. Bit counter is 0. Synchroniser and edge flops are 1 (idle bus).
- ps2_clk and ps2_dat each pass through 2 flops. A falling edge (fall) is registered previous = 1 and current = 0. Data is sampled from the synchronised ps2_dat in the same cycle as fall.
- FSM advances only on fall:
  - IDLE: sampled 0 -> DATA with bit_cnt = 0. Sampled 1 -> stay in IDLE; no error.
  - DATA: shift the sample in LSB-first (shreg <= {dat, shreg[7:1]}). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always return to IDLE. Parity is ok when the XOR of the 8 data bits and the parity bit is 1. If stop = 1 and parity is ok, accept the byte; otherwise pulse frame_err.
- Latency: on an accepted byte, byte_valid and byte_data update in the cycle after the stop-bit fall cycle. Total is 4 clk after the raw pin edge.
- Prefix handling on each accepted byte:
  - E0: set ext_flag; no key event.
  - F0: set brk_flag; no key event.
  - Any other byte: key_valid pulses in the same cycle as byte_valid, with key_code = byte, key_ext = ext_flag, key_break = brk_flag. Both flags then clear.
- byte_valid pulses for every accepted byte, prefixes included.
- frame_err clears both prefix flags. A byte is never emitted on a frame with an error.
- Back-to-back frames: the IDLE start-bit check must be possible on the fall immediately after STOP, with no dead edges.
- Reset mid-frame: the partial frame is discarded; no pulses in the reset cycle or the cycle after.
- Output pulses are exactly 1 cycle wide. No backpressure: the consumer must sample on the pulse.

Optional Feature:
PS2_TIMEOUT_EN:
- Defined: while FSM != IDLE, a CNT_W counter increments each clk and clears on every fall. When it reaches TIMEOUT_CYCLES: FSM -> IDLE, frame_err pulses once, and prefix flags clear. The counter is held at 0 in IDLE.
- Undefined: no counter logic. A stalled partial frame waits indefinitely and resumes on the next fall.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - constants PS2_EXT_PREFIX = 8'hE0, PS2_BRK_PREFIX = 8'hF0, PS2_FRAME_BITS = 11
  - the shared per-player key-code constants used downstream
- Sub-module ps2_sync_edge: 2-flop synchroniser for both pins plus the fall detector. Outputs the sync'd dat and the fall strobe.

Test Plan:
- Frame 0x1C (bits after start 0: 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one byte_valid with byte_data = 1C; key_valid with key_code = 1C, key_ext = 0, key_break = 0; 4 clk after the stop edge.
- F0 (parity 1) then 1C -> byte_valid twice (F0, 1C); key_valid once with key_code = 1C, key_break = 1, key_ext = 0.
- E0 F0 75 -> three byte_valid pulses; a single key_valid with key_code = 75, key_ext = 1, key_break = 1. A following plain 75 -> key_ext = 0, key_break = 0.
- Error frames, then recovery:
  - 0x1C sent with parity 1 -> frame_err pulse, no byte_valid.
  - 0x1C sent with stop 0 -> frame_err pulse, no byte_valid.
  - F0 followed by a bad frame, then 1C -> key_break = 0 on the 1C event.
- Reset asserted after 5 bits of a frame -> no pulses. A following clean frame 0x75 -> byte_data = 75.
- PS2_TIMEOUT_EN: stop after 4 bits for 50000 clk -> frame_err on cycle 50000, FSM back to IDLE. A following clean 0x1C is received correctly. Without the macro: the same stall produces no frame_err.
